niu_sii_req_arb: RTL
====================

NIU_SII_REQ_ARB -- requirements
Module: niu_sii_req_arb

Interface
REQ-001 SHALL have parameter OQ_DEPTH, default 16, giving SII ordered-queue credits available at reset.
REQ-002 SHALL have parameter BQ_DEPTH, default 16, giving SII bypass-queue credits available at reset.
REQ-003 SHALL have port iol2clk, input, 1, the only clock; all state on its rising edge.
REQ-004 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cN_req, input, 1, request valid from DMA client N, N in {0,1}.
REQ-006 SHALL have ports cN_wr, input, 1: 1 = 64B DMA write, 0 = DMA read.
REQ-007 SHALL have ports cN_byp, input, 1: 1 = bypass queue, 0 = ordered queue.
REQ-008 SHALL have ports cN_hdr, input, 128, request header; held stable while cN_req=1.
REQ-009 SHALL have ports cN_data, input, 128, and cN_be, input, 16: current write payload beat and byte enables.
REQ-010 SHALL have ports cN_gnt, output, 1: one-cycle pulse in the header cycle of client N.
REQ-011 SHALL have ports cN_dack, output, 1: pulse per payload beat consumed from client N.
REQ-012 SHALL have ports niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16, outputs, 1 each.
REQ-013 SHALL have ports niu_sii_data, output, 128; niu_sii_parity, output, 8; niu_sii_be, output, 16.
REQ-014 SHALL have ports sii_niu_oqdq and sii_niu_bqdq, inputs, 1: one-cycle ordered/bypass credit returns.
REQ-015 SHALL have port cred_err, output, 1: sticky credit-overflow flag.

Function
REQ-016 SHALL implement FSM IDLE, HDR, PAY with a 2-bit beat counter; all niu_sii_* outputs registered.
REQ-017 SHALL treat client N as eligible when cN_req=1 and credit for its target queue (cN_byp) is >0.
REQ-018 SHALL arbitrate round-robin between eligible clients, favouring the client not granted last; after reset client 0 is favoured.
REQ-019 SHALL arbitrate in IDLE, in HDR of a read, and in PAY beat 3, so back-to-back headers occur with no idle cycle.
REQ-020 SHALL in HDR drive hdr_vld=1, reqbypass=cN_byp, datareq=cN_wr, data=cN_hdr, be=0, and pulse cN_gnt.
REQ-021 SHALL after a write HDR spend exactly 4 PAY cycles driving cN_data/cN_be, hdr_vld=0, datareq=0, one cN_dack per beat.
REQ-022 SHALL drive niu_sii_datareq16=0 always; 16B writes are not issued.
REQ-023 SHALL drive niu_sii_parity[i] = XOR of niu_sii_data[16i+15:16i], i=0..7, every cycle.
REQ-024 SHALL drive data, be and all valid strobes to 0 in IDLE.
REQ-025 SHALL decrement the target-queue credit in the HDR cycle and increment it on the matching dq pulse; both in one cycle leave it unchanged.
REQ-026 SHALL hold a credit at its depth and set cred_err when a dq pulse arrives at full credit; cred_err clears only on reset.
REQ-027 SHALL not grant a client with zero target credit; the other eligible client is served instead.
REQ-028 SHALL ignore cN_req deassertion mid-payload; the 4 beats always complete.

Reset
REQ-029 SHALL on rst_l=0 force IDLE, beat=0, all outputs 0, oq credit=OQ_DEPTH, bq credit=BQ_DEPTH, cred_err=0, RR pointer to client 0.
REQ-030 SHALL on reset mid-payload abandon the burst; first cycle after release emits no payload beat.

Verification
REQ-031 c0 read, byp=0 -> next cycle hdr_vld=1, datareq=0, reqbypass=0, c0_gnt=1, oq credit 16->15.
REQ-032 c1 write, byp=1 -> 1 HDR + 4 PAY cycles, 4 c1_dack pulses, parity matches data each cycle, bq credit 16->15.
REQ-033 c0 and c1 requesting reads continuously -> headers alternate 0,1,0,1 on consecutive cycles.
REQ-034 OQ_DEPTH=2, three ordered reads, no oqdq -> two headers then stall; one oqdq pulse -> third header next arbitration.
REQ-035 oqdq at credit 16 -> credit stays 16, cred_err=1 until rst_l.
REQ-036 rst_l low during PAY beat 2 -> all outputs 0 immediately; no payload after release.

Source files
------------

// File: rtl/niu_sii_req_arb.sv
// rtl/niu_sii_req_arb.sv - two-client round-robin DMA request arbiter toward the SII ordered/bypass queues
module niu_sii_req_arb #(
    parameter int OQ_DEPTH = 16,
    parameter int BQ_DEPTH = 16
) (
    input  logic         iol2clk,
    input  logic         rst_l,
    input  logic         c0_req,
    input  logic         c0_wr,
    input  logic         c0_byp,
    input  logic [127:0] c0_hdr,
    input  logic [127:0] c0_data,
    input  logic [15:0]  c0_be,
    input  logic         c1_req,
    input  logic         c1_wr,
    input  logic         c1_byp,
    input  logic [127:0] c1_hdr,
    input  logic [127:0] c1_data,
    input  logic [15:0]  c1_be,
    input  logic         sii_niu_oqdq,
    input  logic         sii_niu_bqdq,
    output logic         c0_gnt,
    output logic         c0_dack,
    output logic         c1_gnt,
    output logic         c1_dack,
    output logic         niu_sii_hdr_vld,
    output logic         niu_sii_reqbypass,
    output logic         niu_sii_datareq,
    output logic         niu_sii_datareq16,
    output logic [127:0] niu_sii_data,
    output logic [7:0]   niu_sii_parity,
    output logic [15:0]  niu_sii_be,
    output logic         cred_err
);

    localparam int OQW = $clog2(OQ_DEPTH + 1);
    localparam int BQW = $clog2(BQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

    state_t         state, state_nxt;
    logic [1:0]     beat, beat_nxt;
    logic           cur, cur_nxt;
    logic           cur_wr, cur_wr_nxt;
    logic           fav, fav_nxt;
    logic [OQW-1:0] oq_cred, oq_cred_nxt;
    logic [BQW-1:0] bq_cred, bq_cred_nxt;
    logic           cred_err_nxt;
    logic           elig0, elig1, arb_ok, grant, sel, sel_byp, oq_dec, bq_dec;
    logic           c0_gnt_nxt, c1_gnt_nxt, c0_dack_nxt, c1_dack_nxt;
    logic           hdr_vld_nxt, reqbypass_nxt, datareq_nxt;
    logic [127:0]   data_nxt;
    logic [15:0]    be_nxt;

    assign niu_sii_datareq16 = 1'b0;

    always_comb begin
        niu_sii_parity = '0;
        for (int i = 0; i < 8; i++) begin
            niu_sii_parity[i] = ^niu_sii_data[16*i +: 16];
        end
    end

    always_comb begin
        elig0   = c0_req && (c0_byp ? (bq_cred != '0) : (oq_cred != '0));
        elig1   = c1_req && (c1_byp ? (bq_cred != '0) : (oq_cred != '0));
        // a new header may follow a read header or the last payload beat directly
        arb_ok  = (state == IDLE) || (state == HDR && !cur_wr) || (state == PAY && beat == 2'd3);
        grant   = arb_ok && (elig0 || elig1);
        sel     = (elig0 && elig1) ? fav : elig1;
        sel_byp = sel ? c1_byp : c0_byp;

        state_nxt     = IDLE;
        beat_nxt      = 2'd0;
        cur_nxt       = cur;
        cur_wr_nxt    = cur_wr;
        fav_nxt       = fav;
        c0_gnt_nxt    = 1'b0;
        c1_gnt_nxt    = 1'b0;
        c0_dack_nxt   = 1'b0;
        c1_dack_nxt   = 1'b0;
        hdr_vld_nxt   = 1'b0;
        reqbypass_nxt = 1'b0;
        datareq_nxt   = 1'b0;
        data_nxt      = '0;
        be_nxt        = '0;

        if (grant) begin
            state_nxt     = HDR;
            cur_nxt       = sel;
            cur_wr_nxt    = sel ? c1_wr : c0_wr;
            fav_nxt       = !sel;
            c0_gnt_nxt    = !sel;
            c1_gnt_nxt    = sel;
            hdr_vld_nxt   = 1'b1;
            reqbypass_nxt = sel_byp;
            datareq_nxt   = sel ? c1_wr : c0_wr;
            data_nxt      = sel ? c1_hdr : c0_hdr;
        end else if ((state == HDR && cur_wr) || (state == PAY && beat != 2'd3)) begin
            state_nxt   = PAY;
            beat_nxt    = (state == HDR) ? 2'd0 : beat + 2'd1;
            c0_dack_nxt = !cur;
            c1_dack_nxt = cur;
            data_nxt    = cur ? c1_data : c0_data;
            be_nxt      = cur ? c1_be : c0_be;
        end
    end

    always_comb begin
        oq_dec       = grant && !sel_byp;
        bq_dec       = grant && sel_byp;
        oq_cred_nxt  = oq_cred;
        bq_cred_nxt  = bq_cred;
        cred_err_nxt = cred_err;
        if (oq_dec && !sii_niu_oqdq) begin
            oq_cred_nxt = oq_cred - OQW'(1);
        end else if (!oq_dec && sii_niu_oqdq) begin
            if (oq_cred == OQW'(OQ_DEPTH)) cred_err_nxt = 1'b1;
            else                          oq_cred_nxt  = oq_cred + OQW'(1);
        end
        if (bq_dec && !sii_niu_bqdq) begin
            bq_cred_nxt = bq_cred - BQW'(1);
        end else if (!bq_dec && sii_niu_bqdq) begin
            if (bq_cred == BQW'(BQ_DEPTH)) cred_err_nxt = 1'b1;
            else                          bq_cred_nxt  = bq_cred + BQW'(1);
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state             <= IDLE;
            beat              <= 2'd0;
            cur               <= 1'b0;
            cur_wr            <= 1'b0;
            fav               <= 1'b0;
            oq_cred           <= OQW'(OQ_DEPTH);
            bq_cred           <= BQW'(BQ_DEPTH);
            cred_err          <= 1'b0;
            c0_gnt            <= 1'b0;
            c1_gnt            <= 1'b0;
            c0_dack           <= 1'b0;
            c1_dack           <= 1'b0;
            niu_sii_hdr_vld   <= 1'b0;
            niu_sii_reqbypass <= 1'b0;
            niu_sii_datareq   <= 1'b0;
            niu_sii_data      <= '0;
            niu_sii_be        <= '0;
        end else begin
            state             <= state_nxt;
            beat              <= beat_nxt;
            cur               <= cur_nxt;
            cur_wr            <= cur_wr_nxt;
            fav               <= fav_nxt;
            oq_cred           <= oq_cred_nxt;
            bq_cred           <= bq_cred_nxt;
            cred_err          <= cred_err_nxt;
            c0_gnt            <= c0_gnt_nxt;
            c1_gnt            <= c1_gnt_nxt;
            c0_dack           <= c0_dack_nxt;
            c1_dack           <= c1_dack_nxt;
            niu_sii_hdr_vld   <= hdr_vld_nxt;
            niu_sii_reqbypass <= reqbypass_nxt;
            niu_sii_datareq   <= datareq_nxt;
            niu_sii_data      <= data_nxt;
            niu_sii_be        <= be_nxt;
        end
    end

endmodule
